param_data_memory: RTL and testbench

//  Parametrised word-addressed data memory for the single-cycle CPU datapath.

---
 rtl/param_data_memory_if.sv | 30 +++
 rtl/param_data_memory.sv | 106 ++++++++++
 tb/tb_param_data_memory.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/param_data_memory_if.sv
// Request/response bus between the CPU load/store unit and the data memory.
// The master drives requests and clear pulses; the slave answers one cycle later.
interface param_data_memory_if #(
    parameter int DATA_W = 16,
    parameter int ABUS_W = 16
);
    localparam int LANES = DATA_W / 8;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ABUS_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [LANES-1:0]  req_be;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              clear_start;
    logic              clear_busy;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be, clear_start,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, clear_busy
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be, clear_start,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, clear_busy
    );
endinterface

// File: rtl/param_data_memory.sv
// Word-addressed data memory with byte-lane writes, registered read response,
// range checking and a one-word-per-cycle hardware clear sequencer.
module param_data_memory #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 6,
    parameter int ABUS_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    param_data_memory_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int LANES = DATA_W / 8;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_IDLE  = 1'b1;

    localparam logic [ADDR_W:0] CLR_LAST = (ADDR_W + 1)'(DEPTH - 1);

    logic [0:0]        state_q, state_d;
    logic [ADDR_W:0]   clr_idx_q, clr_idx_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              accept;
    logic              in_range;
    logic              wr_en;
    logic              rd_en;
    logic              clr_we;
    logic [ADDR_W-1:0] idx;

    // Range test uses every address bit so high addresses never alias low words.
    assign in_range = (bus.req_addr >> ADDR_W) == '0;
    assign idx      = bus.req_addr[ADDR_W-1:0];

    assign bus.req_ready  = (state_q == ST_IDLE) && !bus.clear_start;
    assign bus.clear_busy = (state_q == ST_CLEAR);

    assign accept = bus.req_valid && bus.req_ready;
    assign wr_en  = accept && bus.req_write && in_range;
    assign rd_en  = accept && !bus.req_write && in_range;
    assign clr_we = (state_q == ST_CLEAR);

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            ST_CLEAR: begin
                if (clr_idx_q == CLR_LAST) begin
                    state_d   = ST_IDLE;
                    clr_idx_d = '0;
                end else begin
                    clr_idx_d = clr_idx_q + (ADDR_W + 1)'(1);
                end
            end
            default: begin
                if (bus.clear_start) begin
                    state_d   = ST_CLEAR;
                    clr_idx_d = '0;
                end
            end
        endcase
    end

    always_comb begin
        rsp_valid_d = accept;
        rsp_err_d   = accept && !in_range;
        rsp_rdata_d = rd_en ? mem_q[idx] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_CLEAR;
            clr_idx_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            clr_idx_q   <= clr_idx_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Array is unreset; the clear sequence after reset initialises every word.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_q[clr_idx_q[ADDR_W-1:0]] <= '0;
        end else if (wr_en) begin
            for (int k = 0; k < LANES; k++) begin
                if (bus.req_be[k]) begin
                    mem_q[idx][k*8 +: 8] <= bus.req_wdata[k*8 +: 8];
                end
            end
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_param_data_memory.sv
// Directed-vector bench for param_data_memory (DATA_W=16, ADDR_W=6, ABUS_W=16).
module tb_param_data_memory;
    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_fail;

    param_data_memory_if #(.DATA_W(16), .ABUS_W(16)) bus ();

    param_data_memory #(.DATA_W(16), .ADDR_W(6), .ABUS_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [1:0]  be;
        logic [15:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vt [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Presents one request for one cycle; on return the response is visible.
    task automatic req(input logic wr, input logic [15:0] a, input logic [15:0] wd,
                       input logic [1:0] be);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        bus.req_be    = be;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (bus.clear_busy && n < 200) begin
            if (bus.req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL ready_during_clear: got %b expected 0", bus.req_ready);
            end
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    function automatic logic [31:0] rsp_word();
        return {13'd0, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata};
    endfunction

    function automatic logic [31:0] rst_word();
        return {11'd0, bus.clear_busy, bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata};
    endfunction

    initial begin
        int n;
        n_vec  = 0;
        n_fail = 0;

        vt[0]  = '{1'b1, 16'd5,     16'hABCD, 2'b11, 16'h0000, 1'b0};
        vt[1]  = '{1'b0, 16'd5,     16'h0000, 2'b00, 16'hABCD, 1'b0};
        vt[2]  = '{1'b1, 16'd9,     16'hFFFF, 2'b11, 16'h0000, 1'b0};
        vt[3]  = '{1'b1, 16'd9,     16'h1234, 2'b01, 16'h0000, 1'b0};
        vt[4]  = '{1'b0, 16'd9,     16'h0000, 2'b00, 16'hFF34, 1'b0};
        vt[5]  = '{1'b1, 16'd9,     16'h5600, 2'b10, 16'h0000, 1'b0};
        vt[6]  = '{1'b0, 16'd9,     16'h0000, 2'b00, 16'h5634, 1'b0};
        vt[7]  = '{1'b1, 16'd63,    16'hBEEF, 2'b11, 16'h0000, 1'b0};
        vt[8]  = '{1'b0, 16'd64,    16'h0000, 2'b00, 16'h0000, 1'b1};
        vt[9]  = '{1'b1, 16'hFFFF,  16'h1111, 2'b11, 16'h0000, 1'b1};
        vt[10] = '{1'b0, 16'd63,    16'h0000, 2'b00, 16'hBEEF, 1'b0};
        vt[11] = '{1'b1, 16'h0045,  16'hDEAD, 2'b11, 16'h0000, 1'b1};
        vt[12] = '{1'b1, 16'd5,     16'h0000, 2'b00, 16'h0000, 1'b0};
        vt[13] = '{1'b0, 16'd5,     16'h0000, 2'b00, 16'hABCD, 1'b0};

        rst_n           = 1'b0;
        bus.req_valid   = 1'b0;
        bus.req_write   = 1'b0;
        bus.req_addr    = '0;
        bus.req_wdata   = '0;
        bus.req_be      = '0;
        bus.clear_start = 1'b0;

        // Reset state and initial clear length
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", rst_word(), {11'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0});
        rst_n = 1'b1;
        count_busy(n);
        check("clear_len_after_reset", n, 64);
        check("ready_after_clear", {31'd0, bus.req_ready}, 32'd1);
        for (int a = 0; a < 64; a++) begin
            req(1'b0, 16'(a), 16'h0, 2'b00);
            check($sformatf("init_zero_%0d", a), rsp_word(), {13'd0, 1'b1, 1'b0, 16'h0000});
        end

        // Back-to-back vector table
        for (int i = 0; i < 14; i++) begin
            req(vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].be);
            check($sformatf("vec%0d", i), rsp_word(),
                  {13'd0, 1'b1, vt[i].exp_err, vt[i].exp_rdata});
        end
        @(posedge clk);
        #1;
        check("no_request_idle", rsp_word(), 32'd0);

        // Clear has priority over a same-cycle request
        bus.clear_start = 1'b1;
        bus.req_valid   = 1'b1;
        bus.req_write   = 1'b0;
        bus.req_addr    = 16'd5;
        #1;
        check("ready_low_on_clear", {31'd0, bus.req_ready}, 32'd0);
        @(posedge clk);
        #1;
        bus.clear_start = 1'b0;
        bus.req_valid   = 1'b0;
        check("req_dropped_on_clear", rsp_word(), 32'd0);
        count_busy(n);
        check("clear_len_start", n, 64);
        req(1'b0, 16'd5, 16'h0, 2'b00);
        check("addr5_cleared", rsp_word(), {13'd0, 1'b1, 1'b0, 16'h0000});

        // Reset while a response is on the bus
        req(1'b1, 16'd63, 16'hBEEF, 2'b11);
        req(1'b0, 16'd63, 16'h0, 2'b00);
        check("rd63_before_reset", rsp_word(), {13'd0, 1'b1, 1'b0, 16'hBEEF});
        rst_n = 1'b0;
        #1;
        check("reset_drops_rsp", rst_word(), {11'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0});
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        count_busy(n);
        check("clear_len_rst2", n, 64);
        req(1'b0, 16'd63, 16'h0, 2'b00);
        check("addr63_cleared", rsp_word(), {13'd0, 1'b1, 1'b0, 16'h0000});

        // Reset in the middle of a clear restarts it from index 0
        req(1'b1, 16'd7, 16'h55AA, 2'b11);
        bus.clear_start = 1'b1;
        @(posedge clk);
        #1;
        bus.clear_start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("busy_mid_clear", {31'd0, bus.clear_busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("reset_mid_clear", rst_word(), {11'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0});
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        count_busy(n);
        check("clear_len_rst3", n, 64);
        req(1'b0, 16'd7, 16'h0, 2'b00);
        check("addr7_cleared", rsp_word(), {13'd0, 1'b1, 1'b0, 16'h0000});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
